// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame loader and the dithering core that sizes
// its frame buffer from the same constants.
package spi_frame_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned MAX_W     = 320;
    localparam int unsigned MAX_H     = 240;
    localparam int unsigned FB_ADDR_W = 17;

    typedef enum logic [3:0] {
        StIdle,
        StWHi,
        StWLo,
        StHHi,
        StHLo,
        StCheck,
        StPixels,
        StDone,
        StError
    } frame_state_t;

endpackage

// File: rtl/spi_frame_loader_if.sv
// Byte-receiver input, frame-buffer write port and status bundle of the frame loader.
// The master modport is the loader itself; slave is the surrounding logic.
interface spi_frame_loader_if #(
    parameter int unsigned ADDR_W = spi_frame_pkg::FB_ADDR_W
);
    logic              SPI_CS;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [15:0]       img_width;
    logic [15:0]       img_height;
    logic              frame_done;
    logic              frame_err;
    logic              busy;

    modport master (
        input  SPI_CS, rx_byte, rx_valid,
        output mem_addr, mem_wdata, mem_we, img_width, img_height, frame_done, frame_err, busy
    );

    modport slave (
        output SPI_CS, rx_byte, rx_valid,
        input  mem_addr, mem_wdata, mem_we, img_width, img_height, frame_done, frame_err, busy
    );
endinterface

// File: rtl/spi_frame_loader.sv
// Parses sync/width/height header from the SPI byte stream and writes the following
// pixel bytes sequentially into the frame buffer. All outputs are registered.
module spi_frame_loader #(
    parameter int unsigned ADDR_W    = spi_frame_pkg::FB_ADDR_W,
    parameter int unsigned MAX_W     = spi_frame_pkg::MAX_W,
    parameter int unsigned MAX_H     = spi_frame_pkg::MAX_H,
    parameter logic [7:0]  SYNC_BYTE = spi_frame_pkg::SYNC_BYTE
) (
    input logic                SPI_CLK,
    input logic                rst,
    spi_frame_loader_if.master bus
);
    import spi_frame_pkg::*;

    localparam logic [15:0] MaxWidth  = 16'(MAX_W);
    localparam logic [15:0] MaxHeight = 16'(MAX_H);

    frame_state_t      state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [31:0]       total_q, total_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic dims_bad;
    logic last_pixel;

    assign dims_bad = (width_q == 16'd0) || (width_q > MaxWidth) ||
                      (height_q == 16'd0) || (height_q > MaxHeight);
    assign last_pixel = (32'(count_q) + 32'd1) == total_q;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        width_d  = width_q;
        height_d = height_q;
        total_d  = total_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid && !bus.SPI_CS && bus.rx_byte == SYNC_BYTE) begin
                    state_d = StWHi;
                    err_d   = 1'b0;
                    count_d = '0;
                end
            end
            StWHi, StWLo, StHHi, StHLo: begin
                if (bus.SPI_CS) begin
                    state_d = StError;
                end else if (bus.rx_valid) begin
                    unique case (state_q)
                        StWHi: begin
                            hi_d    = bus.rx_byte;
                            state_d = StWLo;
                        end
                        StWLo: begin
                            width_d = {hi_q, bus.rx_byte};
                            state_d = StHHi;
                        end
                        StHHi: begin
                            hi_d    = bus.rx_byte;
                            state_d = StHLo;
                        end
                        default: begin
                            height_d = {hi_q, bus.rx_byte};
                            state_d  = StCheck;
                        end
                    endcase
                end
            end
            StCheck: begin
                // Any byte landing here is dropped; the header is fully latched by now.
                total_d = 32'(width_q) * 32'(height_q);
                if (bus.SPI_CS || dims_bad) begin
                    state_d = StError;
                end else begin
                    state_d = StPixels;
                end
            end
            StPixels: begin
                if (bus.SPI_CS) begin
                    state_d = StError;
                end else if (bus.rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = count_q;
                    wdata_d = bus.rx_byte;
                    count_d = count_q + 1'b1;
                    if (last_pixel) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone, StError: begin
                if (bus.SPI_CS) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StError) begin
            err_d = 1'b1;
        end
        busy_d = !(state_d inside {StIdle, StDone, StError});
    end

    always_ff @(posedge SPI_CLK) begin
        if (rst) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            width_q  <= '0;
            height_q <= '0;
            total_q  <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            width_q  <= width_d;
            height_q <= height_d;
            total_q  <= total_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_we     = we_q;
    assign bus.img_width  = width_q;
    assign bus.img_height = height_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = busy_q;

endmodule
